// File: rtl/decimal_entry_if.sv
// Key-entry bus for decimal_entry: keypad codes in, entry state and commit results out.
// The master side drives keys; the slave side is the entry block.
interface decimal_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [14:0] val;
  logic [2:0]  digit_count;
  logic        neg;
  logic        commit_valid;
  logic [14:0] commit_val;
  logic        overflow;

  modport master (
    output key_valid, key_code,
    input  key_ready, val, digit_count, neg, commit_valid, commit_val, overflow
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, val, digit_count, neg, commit_valid, commit_val, overflow
  );
endinterface

// File: rtl/decimal_entry.sv
// Keypad decimal entry: accumulates up to five digits, backspace by serial divide-by-10.
// Define SIGNED_ENTRY_EN for signed entry (sign key, limit 16383, two's-complement commit).
//
// state | meaning
// IDLE  | accepting keys, key_ready high
// DIV   | 15-cycle restoring divide of val by 10 for backspace
module decimal_entry (
  input  logic           clk,
  input  logic           rst,
  decimal_entry_if.slave bus
);

`ifdef SIGNED_ENTRY_EN
  localparam logic [17:0] LIMIT   = 18'd16383;
  localparam bit          SIGN_EN = 1'b1;
`else
  localparam logic [17:0] LIMIT   = 18'd32767;
  localparam bit          SIGN_EN = 1'b0;
`endif

  localparam logic [3:0] KEY_BSP   = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_SIGN  = 4'hD;
  localparam logic [3:0] DIV_LAST  = 4'd14;

  typedef enum logic {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        key_ready_c;
  logic        key_accept;

  logic [14:0] val_q;
  logic [2:0]  cnt_q;
  logic        neg_q;
  logic        commit_valid_q;
  logic [14:0] commit_val_q;
  logic        overflow_q;

  logic [3:0]  div_cnt;
  logic [14:0] div_dq;
  logic [3:0]  div_rem;

  logic        is_digit;
  logic        is_bsp;
  logic        div_done;
  logic [17:0] val_ext;
  logic [17:0] digit_next;
  logic        digit_reject;
  logic        digit_counts;
  logic [4:0]  div_trial;
  logic        div_ge;
  logic [3:0]  div_rem_nxt;
  logic [14:0] div_dq_nxt;
  logic [14:0] commit_calc;

  assign key_accept = bus.key_valid && key_ready_c;
  assign is_digit   = (bus.key_code <= 4'd9);
  assign is_bsp     = (bus.key_code == KEY_BSP);
  assign div_done   = (state == ST_DIV) && (div_cnt == 4'd0);

  // val*10 + d as shift-add; widened so the limit compare cannot wrap
  assign val_ext      = {3'b000, val_q};
  assign digit_next   = (val_ext << 3) + (val_ext << 1) + {14'd0, bus.key_code};
  assign digit_reject = (cnt_q == 3'd5) || (digit_next > LIMIT);
  assign digit_counts = !((bus.key_code == 4'd0) && (val_q == 15'd0));

  // One restoring step: quotient bits shift into div_dq as dividend bits shift out
  assign div_trial   = {div_rem, div_dq[14]};
  assign div_ge      = (div_trial >= 5'd10);
  assign div_rem_nxt = div_ge ? 4'(div_trial - 5'd10) : div_trial[3:0];
  assign div_dq_nxt  = {div_dq[13:0], div_ge};

  assign commit_calc = (SIGN_EN && neg_q && (val_q != 15'd0)) ? (~val_q + 15'd1) : val_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (key_accept && is_bsp && (cnt_q != 3'd0)) state_nxt = ST_DIV;
      ST_DIV:  if (div_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready_c = 1'b0;
    case (state)
      ST_IDLE: key_ready_c = 1'b1;
      default: key_ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q          <= 15'd0;
      cnt_q          <= 3'd0;
      neg_q          <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_val_q   <= 15'd0;
      overflow_q     <= 1'b0;
      div_cnt        <= 4'd0;
      div_dq         <= 15'd0;
      div_rem        <= 4'd0;
    end else begin
      overflow_q     <= 1'b0;
      commit_valid_q <= 1'b0;
      if (state == ST_DIV) begin
        div_dq  <= div_dq_nxt;
        div_rem <= div_rem_nxt;
        div_cnt <= div_cnt - 4'd1;
        if (div_cnt == 4'd0) begin
          val_q <= div_dq_nxt;
          cnt_q <= cnt_q - 3'd1;
        end
      end else if (key_accept) begin
        if (is_digit) begin
          if (digit_reject) begin
            overflow_q <= 1'b1;
          end else begin
            val_q <= digit_next[14:0];
            if (digit_counts) cnt_q <= cnt_q + 3'd1;
          end
        end else begin
          case (bus.key_code)
            KEY_BSP: begin
              if (cnt_q != 3'd0) begin
                div_dq  <= val_q;
                div_rem <= 4'd0;
                div_cnt <= DIV_LAST;
              end
            end
            KEY_CLEAR: begin
              val_q <= 15'd0;
              cnt_q <= 3'd0;
              neg_q <= 1'b0;
            end
            KEY_ENTER: begin
              commit_valid_q <= 1'b1;
              commit_val_q   <= commit_calc;
              val_q          <= 15'd0;
              cnt_q          <= 3'd0;
              neg_q          <= 1'b0;
            end
            KEY_SIGN: begin
              if (SIGN_EN) neg_q <= ~neg_q;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.key_ready    = key_ready_c;
  assign bus.val          = val_q;
  assign bus.digit_count  = cnt_q;
  assign bus.neg          = SIGN_EN ? neg_q : 1'b0;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_val   = commit_val_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: digit entry, limits, backspace divide, commit, resets.
// Signed-build vectors run only when SIGNED_ENTRY_EN is defined.
module tb_decimal_entry;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decimal_entry_if bus ();

  decimal_entry dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.key_ready && n < 40) begin
      step();
      n++;
    end
    check("ready_timeout", {31'd0, bus.key_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(bus.commit_valid && bus.overflow)) else begin
        errors++;
        $error("FAIL pulse_exclusive observed both expected one");
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", {31'd0, bus.key_ready}, 32'd1);
    check("rst_val", {17'd0, bus.val}, 32'd0);
    check("rst_cnt", {29'd0, bus.digit_count}, 32'd0);
    check("rst_neg", {31'd0, bus.neg}, 32'd0);
    check("rst_cv", {31'd0, bus.commit_valid}, 32'd0);
    check("rst_cval", {17'd0, bus.commit_val}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);

`ifndef SIGNED_ENTRY_EN
    // 32767 is the unsigned ceiling
    press(4'd3); press(4'd2); press(4'd7); press(4'd6);
    check("max_val4", {17'd0, bus.val}, 32'd3276);
    press(4'd7);
    check("max_val", {17'd0, bus.val}, 32'd32767);
    check("max_cnt", {29'd0, bus.digit_count}, 32'd5);
    check("max_ovf", {31'd0, bus.overflow}, 32'd0);
    press(4'hC);
    check("ent_cv", {31'd0, bus.commit_valid}, 32'd1);
    check("ent_cval", {17'd0, bus.commit_val}, 32'd32767);
    check("ent_val", {17'd0, bus.val}, 32'd0);
    check("ent_cnt", {29'd0, bus.digit_count}, 32'd0);
    step();
    check("ent_cv_drop", {31'd0, bus.commit_valid}, 32'd0);
    check("ent_cval_hold", {17'd0, bus.commit_val}, 32'd32767);

    press(4'd3); press(4'd2); press(4'd7); press(4'd6); press(4'd8);
    check("ovf_pulse", {31'd0, bus.overflow}, 32'd1);
    check("ovf_val", {17'd0, bus.val}, 32'd3276);
    check("ovf_cnt", {29'd0, bus.digit_count}, 32'd4);
    step();
    check("ovf_drop", {31'd0, bus.overflow}, 32'd0);
`endif

    // Backspace from 12345 with a digit held through the divide
    press(4'hB);
    check("clr_val", {17'd0, bus.val}, 32'd0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("div_pre_val", {17'd0, bus.val}, 32'd12345);
    press(4'hA);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd9;
    for (int i = 0; i < 15; i++) begin
      check("div_ready_low", {31'd0, bus.key_ready}, 32'd0);
      check("div_val_hold", {17'd0, bus.val}, 32'd12345);
      check("div_cnt_hold", {29'd0, bus.digit_count}, 32'd5);
      step();
    end
    bus.key_valid = 1'b0;
    check("div_ready_back", {31'd0, bus.key_ready}, 32'd1);
    check("div_val", {17'd0, bus.val}, 32'd1234);
    check("div_cnt", {29'd0, bus.digit_count}, 32'd4);
    step();
    check("div_no_accept", {17'd0, bus.val}, 32'd1234);

    // Leading zeros and backspace at empty
    press(4'hB);
    press(4'd0);
    check("lz_cnt0", {29'd0, bus.digit_count}, 32'd0);
    press(4'd0);
    press(4'd5);
    check("lz_val", {17'd0, bus.val}, 32'd5);
    check("lz_cnt", {29'd0, bus.digit_count}, 32'd1);
    press(4'hA);
    wait_ready();
    check("bs1_val", {17'd0, bus.val}, 32'd0);
    check("bs1_cnt", {29'd0, bus.digit_count}, 32'd0);
    press(4'hA);
    check("bs2_nodiv", {31'd0, bus.key_ready}, 32'd1);
    check("bs2_val", {17'd0, bus.val}, 32'd0);

    // Ignored codes
    press(4'd4); press(4'd2);
    press(4'hE);
    press(4'hF);
    check("ign_val", {17'd0, bus.val}, 32'd42);
    check("ign_cnt", {29'd0, bus.digit_count}, 32'd2);
`ifndef SIGNED_ENTRY_EN
    press(4'hD);
    check("sign_noop_neg", {31'd0, bus.neg}, 32'd0);
    check("sign_noop_val", {17'd0, bus.val}, 32'd42);
`endif
    press(4'hA);
    wait_ready();
    check("bs42_val", {17'd0, bus.val}, 32'd4);

    // Reset on DIV cycle 7
    press(4'hB);
    press(4'd9); press(4'd9); press(4'd9);
    press(4'hA);
    repeat (6) step();
    check("rdiv_pre", {17'd0, bus.val}, 32'd999);
    check("rdiv_busy", {31'd0, bus.key_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rdiv_val", {17'd0, bus.val}, 32'd0);
    check("rdiv_ready", {31'd0, bus.key_ready}, 32'd1);
    check("rdiv_cnt", {29'd0, bus.digit_count}, 32'd0);
    repeat (10) step();
    check("rdiv_no_late", {17'd0, bus.val}, 32'd0);

    // Reset wins over a same-edge key
    press(4'd7);
    check("rpri_pre", {17'd0, bus.val}, 32'd7);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    check("rpri_val", {17'd0, bus.val}, 32'd0);
    check("rpri_cnt", {29'd0, bus.digit_count}, 32'd0);

`ifdef SIGNED_ENTRY_EN
    press(4'd1); press(4'd6); press(4'd3); press(4'd8); press(4'd3);
    check("s_max", {17'd0, bus.val}, 32'd16383);
    press(4'hB);
    press(4'd1); press(4'd6); press(4'd3); press(4'd8); press(4'd4);
    check("s_ovf", {31'd0, bus.overflow}, 32'd1);
    check("s_ovf_val", {17'd0, bus.val}, 32'd1638);
    press(4'hB);
    press(4'd1); press(4'd0); press(4'd0);
    press(4'hD);
    check("s_neg", {31'd0, bus.neg}, 32'd1);
    press(4'hC);
    check("s_cv", {31'd0, bus.commit_valid}, 32'd1);
    check("s_cval", {17'd0, bus.commit_val}, 32'h7F9C);
    check("s_neg_clr", {31'd0, bus.neg}, 32'd0);
    press(4'hD);
    press(4'hC);
    check("s_negzero", {17'd0, bus.commit_val}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
